pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard scheduler for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It tracks the destination registers of in-flight instructions in a 3-entry scoreboard (EX, MEM, WB) and compares them against the ID-stage source registers. From that comparison it drives IF/ID stall, bubble injection into EX, and operand-forward selects. It also sequences multi-cycle flushes after taken jumps, jr and branches, and keeps saturating stall/flush performance counters. It sits beside the decoder and drives the pipeline-register enables in cpu.

Parameters:
FWD_EN, 0, 1 = forwarding paths exist in the datapath; 0 = stall until the producer has left WB.
BR_PENALTY, 1, number of flush cycles after an accepted redirect; legal range 1..3.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID stage holds a real instruction
id_rs  in  5  ID source register A
id_rt  in  5  ID source register B
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_wr_en  in  1  instruction writes the register file
id_wr_addr  in  5  destination register
id_is_load  in  1  result comes from data memory (lw)
redirect  in  1  ID resolved a taken jmp/jr/branch
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
flush  out  1  kill the instruction in IF/ID (turn it into a NOP)
fwd_a  out  2  operand A select: 0 regfile, 1 EX result, 2 MEM result, 3 WB data
fwd_b  out  2  operand B select, same encoding as fwd_a
stall_cycles  out  CNT_W  saturating count of stall cycles
flush_cycles  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset: all scoreboard entries invalid; flush counter 0; stall=0, flush=0, fwd_a=fwd_b=0; both perf counters 0. Reset asserted mid-operation discards pending flush cycles and all entries on that edge.
- Scoreboard entry = {valid, addr[4:0], load}. Entries with addr==0 are never written as valid; register 0 never creates a hazard.
- Issue: issue = id_valid & !stall & !flush.
- Shift every cycle: wb <= mem; mem <= ex; ex <= {issue & id_wr_en & (id_wr_addr!=0), id_wr_addr, id_is_load}. A stall therefore inserts an invalid entry into EX.
- Match: a source matches stage S when its use bit is set, the source register is nonzero, S.valid is set, and S.addr equals the source register.
- FWD_EN=0:
  - stall = id_valid & !flush & (any source matches EX, MEM or WB).
  - The regfile writes at the end of WB, and a same-cycle read returns the old value, so a WB match also stalls.
  - fwd_a and fwd_b are held at 0.
- FWD_EN=1:
  - stall = id_valid & !flush & (a source matches EX and ex.load). This is the load-use case: exactly 1 stall cycle.
  - fwd priority per operand: EX (1) > MEM (2) > WB (3) > regfile (0).
  - While stall or flush is high, fwd is 0.
- All outputs except the counters are combinational from the current scoreboard, flush state and ID inputs.
- Redirect:
  - Accepted when redirect & id_valid & !stall & !flush.
  - An accepted redirect loads the flush counter with BR_PENALTY. flush is high while the counter is nonzero; the counter decrements each cycle.
  - Redirect while stalled is ignored. The instruction re-presents it once the stall clears.
  - Redirect while flush is high is ignored, because that ID instruction is being killed.
  - The redirecting instruction itself issues normally on its accept cycle.
- Simultaneous stall and flush: flush dominates and stall is forced 0.
- Counters:
  - stall_cycles increments each cycle stall=1; flush_cycles increments each cycle flush=1.
  - Both saturate at all-ones with no wrap.
  - Clearing is by reset only.

Test Plan:
- FWD_EN=0: addi $1 issues, next cycle add $2,$1,$1 in ID -> stall=1 for exactly 3 cycles, then issue; stall_cycles=3.
- FWD_EN=1: lw $3 then add $4,$3,$0 -> stall=1 for 1 cycle, then fwd_a=2 (MEM) on the issue cycle; dependent ALU-ALU pair -> no stall, fwd_a=1.
- FWD_EN=1: $5 written by instructions in both EX and MEM, consumer reads $5 on both operands -> fwd_a=fwd_b=1 (EX wins).
- Writes and reads of $0 with id_wr_en=1 -> never stall, fwd=0, no scoreboard entry becomes valid.
- BR_PENALTY=2: redirect accepted at cycle N -> flush=1 at cycles N+1 and N+2 and 0 at N+3; a second redirect at N+1 is ignored; flush_cycles=2.
- Reset asserted during the second of 3 stall cycles -> next cycle stall=0, flush=0, counters 0, the same ID instruction issues with no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: scoreboards in-flight destinations,
// drives IF/ID stall, operand forwarding selects, redirect flushes and perf counters.
module pipeline_hazard_ctrl #(
   parameter int FWD_EN     = 0,
   parameter int BR_PENALTY = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr_en,
   input  logic [4:0]       id_wr_addr,
   input  logic             id_is_load,
   input  logic             redirect,
   output logic             stall,
   output logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);

   localparam logic [1:0]       PENALTY = 2'(BR_PENALTY);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Only the EX entry's load bit matters: a load result is ready once it reaches MEM.
   logic       exValid, memValid, wbValid;
   logic [4:0] exAddr, memAddr, wbAddr;
   logic       exLoad;
   logic [1:0] flushCnt;

   logic flushing, issue, accept, hazard;
   logic aEx, aMem, aWb, bEx, bMem, bWb;

   function automatic logic srcMatch(input logic useSrc, input logic [4:0] src,
                                     input logic entValid, input logic [4:0] entAddr);
      return useSrc && (src != 5'd0) && entValid && (entAddr == src);
   endfunction

   function automatic logic [1:0] fwdSel(input logic mEx, input logic mMem, input logic mWb);
      if (mEx)       return 2'd1;
      else if (mMem) return 2'd2;
      else if (mWb)  return 2'd3;
      else           return 2'd0;
   endfunction

   always_comb begin
      aEx  = srcMatch(id_use_rs, id_rs, exValid,  exAddr);
      aMem = srcMatch(id_use_rs, id_rs, memValid, memAddr);
      aWb  = srcMatch(id_use_rs, id_rs, wbValid,  wbAddr);
      bEx  = srcMatch(id_use_rt, id_rt, exValid,  exAddr);
      bMem = srcMatch(id_use_rt, id_rt, memValid, memAddr);
      bWb  = srcMatch(id_use_rt, id_rt, wbValid,  wbAddr);

      flushing = (flushCnt != 2'd0);

      // Without forwarding even a WB producer stalls: the regfile read sees the old value.
      if (FWD_EN != 0) hazard = (aEx | bEx) & exLoad;
      else             hazard = aEx | aMem | aWb | bEx | bMem | bWb;

      stall  = id_valid & ~flushing & hazard;
      flush  = flushing;
      issue  = id_valid & ~stall & ~flushing;
      accept = redirect & issue;

      fwd_a = 2'd0;
      fwd_b = 2'd0;
      if ((FWD_EN != 0) && !stall && !flushing) begin
         fwd_a = fwdSel(aEx, aMem, aWb);
         fwd_b = fwdSel(bEx, bMem, bWb);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exValid      <= 1'b0;
         exAddr       <= 5'd0;
         exLoad       <= 1'b0;
         memValid     <= 1'b0;
         memAddr      <= 5'd0;
         wbValid      <= 1'b0;
         wbAddr       <= 5'd0;
         flushCnt     <= 2'd0;
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         exValid  <= issue & id_wr_en & (id_wr_addr != 5'd0);
         exAddr   <= id_wr_addr;
         exLoad   <= id_is_load;
         memValid <= exValid;
         memAddr  <= exAddr;
         wbValid  <= memValid;
         wbAddr   <= memAddr;

         if (accept)        flushCnt <= PENALTY;
         else if (flushing) flushCnt <= flushCnt - 2'd1;

         if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
         if (flush && (flush_cycles != '1)) flush_cycles <= flush_cycles + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a no-forwarding and a forwarding instance, checked
// against a per-cycle issue-log model with directed scenarios and random traffic.
module tb_pipeline_hazard_ctrl;

   localparam int LOGN = 4096;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       vld[2], useRs[2], useRt[2], wrEn[2], isLd[2], redir[2];
   logic [4:0] rsA[2], rtA[2], wrA[2];
   logic       stallO[2], flushO[2];
   logic [1:0] faO[2], fbO[2];
   logic [7:0] sc0, fc0;
   logic [3:0] sc1, fc1;

   pipeline_hazard_ctrl #(.FWD_EN(0), .BR_PENALTY(3), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .id_valid(vld[0]), .id_rs(rsA[0]), .id_rt(rtA[0]),
      .id_use_rs(useRs[0]), .id_use_rt(useRt[0]), .id_wr_en(wrEn[0]), .id_wr_addr(wrA[0]),
      .id_is_load(isLd[0]), .redirect(redir[0]), .stall(stallO[0]), .flush(flushO[0]),
      .fwd_a(faO[0]), .fwd_b(fbO[0]), .stall_cycles(sc0), .flush_cycles(fc0));

   pipeline_hazard_ctrl #(.FWD_EN(1), .BR_PENALTY(2), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .id_valid(vld[1]), .id_rs(rsA[1]), .id_rt(rtA[1]),
      .id_use_rs(useRs[1]), .id_use_rt(useRt[1]), .id_wr_en(wrEn[1]), .id_wr_addr(wrA[1]),
      .id_is_load(isLd[1]), .redirect(redir[1]), .stall(stallO[1]), .flush(flushO[1]),
      .fwd_a(faO[1]), .fwd_b(fbO[1]), .stall_cycles(sc1), .flush_cycles(fc1));

   // Reference model: log of what each instance issued on each cycle.
   int         fwdEn[2]  = '{0, 1};
   int         pen[2]    = '{3, 2};
   int         satMax[2] = '{255, 15};
   bit         logV[2][LOGN];
   logic [4:0] logA[2][LOGN];
   bit         logL[2][LOGN];
   int         mark[2], lastAcc[2], expSc[2], expFc[2];
   int         cyc;
   bit         expStall[2], expFlush[2];
   int         expFa[2], expFb[2];
   logic       obsStall[2], obsFlush[2];
   logic [1:0] obsFa[2], obsFb[2];

   int tests = 0;
   int failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Distance (1=EX, 2=MEM, 3=WB) to the youngest in-flight producer of r, 0 if none.
   function automatic int nearest(int k, logic useSrc, logic [4:0] r);
      if (!useSrc || r == 5'd0) return 0;
      for (int d = 1; d <= 3; d++) begin
         int idx = cyc - d;
         if (idx >= 0 && idx >= mark[k] && logV[k][idx] && logA[k][idx] == r) return d;
      end
      return 0;
   endfunction

   function automatic void predict(int k);
      int  dA, dB, age;
      bit  fl, hz;
      age = cyc - lastAcc[k];
      fl  = (age >= 1) && (age <= pen[k]);
      dA  = nearest(k, useRs[k], rsA[k]);
      dB  = nearest(k, useRt[k], rtA[k]);
      if (fwdEn[k] != 0) hz = (dA == 1 || dB == 1) && logL[k][cyc-1];
      else               hz = (dA != 0) || (dB != 0);
      expStall[k] = vld[k] && !fl && hz;
      expFlush[k] = fl;
      expFa[k] = (fwdEn[k] != 0 && !expStall[k] && !fl) ? dA : 0;
      expFb[k] = (fwdEn[k] != 0 && !expStall[k] && !fl) ? dB : 0;
   endfunction

   function automatic void update(int k);
      bit issue;
      issue = vld[k] && !expStall[k] && !expFlush[k];
      if (reset) begin
         logV[k][cyc] = 1'b0;
         mark[k]      = cyc + 1;
         lastAcc[k]   = -100;
         expSc[k]     = 0;
         expFc[k]     = 0;
      end else begin
         logV[k][cyc] = issue && wrEn[k] && (wrA[k] != 5'd0);
         logA[k][cyc] = wrA[k];
         logL[k][cyc] = isLd[k];
         if (issue && redir[k]) lastAcc[k] = cyc;
         if (expStall[k] && expSc[k] < satMax[k]) expSc[k]++;
         if (expFlush[k] && expFc[k] < satMax[k]) expFc[k]++;
      end
   endfunction

   // One cycle: inputs already set at the falling edge; check, clock, update model.
   task automatic step();
      #1;
      for (int k = 0; k < 2; k++) begin
         predict(k);
         chk($sformatf("u%0d_stall@%0d", k, cyc), stallO[k], expStall[k]);
         chk($sformatf("u%0d_flush@%0d", k, cyc), flushO[k], expFlush[k]);
         chk($sformatf("u%0d_fwd_a@%0d", k, cyc), faO[k], expFa[k]);
         chk($sformatf("u%0d_fwd_b@%0d", k, cyc), fbO[k], expFb[k]);
         obsStall[k] = stallO[k];
         obsFlush[k] = flushO[k];
         obsFa[k]    = faO[k];
         obsFb[k]    = fbO[k];
      end
      chk($sformatf("u0_stall_cycles@%0d", cyc), sc0, expSc[0]);
      chk($sformatf("u0_flush_cycles@%0d", cyc), fc0, expFc[0]);
      chk($sformatf("u1_stall_cycles@%0d", cyc), sc1, expSc[1]);
      chk($sformatf("u1_flush_cycles@%0d", cyc), fc1, expFc[1]);
      @(posedge clk);
      for (int k = 0; k < 2; k++) update(k);
      cyc++;
      @(negedge clk);
   endtask

   task automatic setInstr(input int k, input logic v, input logic [4:0] rs, input logic ur,
                           input logic [4:0] rt, input logic ut, input logic we,
                           input logic [4:0] wa, input logic ld, input logic rd);
      vld[k] = v;   rsA[k] = rs;   useRs[k] = ur; rtA[k] = rt; useRt[k] = ut;
      wrEn[k] = we; wrA[k] = wa;   isLd[k] = ld;  redir[k] = rd;
   endtask

   task automatic setIdle(input int k);
      setInstr(k, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      int held;
      reset = 1'b1;
      setIdle(0);
      setIdle(1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
         mark[k] = 0; lastAcc[k] = -100; expSc[k] = 0; expFc[k] = 0;
      end
      reset = 1'b0;
      chk("rst_u0_stall", stallO[0], 1'b0);
      chk("rst_u1_flush", flushO[1], 1'b0);
      chk("rst_u1_fwd_a", faO[1], 2'd0);
      chk("rst_u0_stall_cycles", sc0, 8'd0);
      step();

      // No forwarding: addi $1 then add $2,$1,$1 holds for three cycles.
      setInstr(0, 1, 5'd0, 0, 5'd0, 0, 1, 5'd1, 0, 0);
      step();
      setInstr(0, 1, 5'd1, 1, 5'd1, 1, 1, 5'd2, 0, 0);
      held = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (obsStall[0] === 1'b1) held++;
         else break;
      end
      chk("t1_stall_len", held, 3);
      chk("t1_stall_cycles", sc0, 8'd3);
      setIdle(0);

      // Forwarding: load-use costs one stall, then MEM forward; ALU-ALU forwards from EX.
      setInstr(1, 1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 1, 0);
      step();
      setInstr(1, 1, 5'd3, 1, 5'd0, 1, 1, 5'd4, 0, 0);
      step();
      chk("t2_loaduse_stall", obsStall[1], 1'b1);
      step();
      chk("t2_issue_nostall", obsStall[1], 1'b0);
      chk("t2_fwd_mem", obsFa[1], 2'd2);
      setInstr(1, 1, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0, 0);
      step();
      setInstr(1, 1, 5'd6, 1, 5'd0, 1, 1, 5'd7, 0, 0);
      step();
      chk("t2_alu_nostall", obsStall[1], 1'b0);
      chk("t2_fwd_ex", obsFa[1], 2'd1);

      // $5 in both EX and MEM: the younger (EX) wins on both operands.
      setInstr(1, 1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0);
      step();
      step();
      setInstr(1, 1, 5'd5, 1, 5'd5, 1, 1, 5'd8, 0, 0);
      step();
      chk("t3_fwd_a_ex", obsFa[1], 2'd1);
      chk("t3_fwd_b_ex", obsFb[1], 2'd1);

      // Register 0 is never a hazard on either instance.
      for (int k = 0; k < 2; k++) setInstr(k, 1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 0);
      step();
      for (int k = 0; k < 2; k++) setInstr(k, 1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0);
      step();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("t4_u%0d_r0_stall", k), obsStall[k], 1'b0);
         chk($sformatf("t4_u%0d_r0_fwd_a", k), obsFa[k], 2'd0);
         chk($sformatf("t4_u%0d_r0_fwd_b", k), obsFb[k], 2'd0);
      end
      setIdle(0);
      setIdle(1);
      repeat (3) step();

      // Redirect with two flush cycles; a redirect during flush is ignored.
      doReset();
      setInstr(1, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1);
      step();
      chk("t5_flush_n", obsFlush[1], 1'b0);
      step();
      chk("t5_flush_n1", obsFlush[1], 1'b1);
      setInstr(1, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
      step();
      chk("t5_flush_n2", obsFlush[1], 1'b1);
      step();
      chk("t5_flush_n3", obsFlush[1], 1'b0);
      chk("t5_flush_cycles", fc1, 4'd2);
      setIdle(1);

      // Reset during the second stall cycle clears everything; the add then issues.
      doReset();
      setInstr(0, 1, 5'd0, 0, 5'd0, 0, 1, 5'd1, 0, 0);
      step();
      setInstr(0, 1, 5'd1, 1, 5'd1, 1, 1, 5'd2, 0, 0);
      step();
      reset = 1'b1;
      step();
      chk("t6_stall_during_reset", obsStall[0], 1'b1);
      reset = 1'b0;
      chk("t6_stall_cycles_clr", sc0, 8'd0);
      chk("t6_flush_cycles_clr", fc0, 8'd0);
      step();
      chk("t6_issue_nostall", obsStall[0], 1'b0);
      chk("t6_noflush", obsFlush[0], 1'b0);
      setIdle(0);

      // Random traffic on a small register set; a stalled instruction is re-presented.
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!expStall[k])
               setInstr(k, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                        $urandom_range(0, 7) == 0);
         end
         reset = ($urandom_range(0, 249) == 0);
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
